logicnet_input_quantizer: RTL and testbench

- Upstream feeder for the first LogicNet layer.
- Accepts raw signed feature samples one per beat and quantizes each to a 2-bit code using per-feature thresholds.
- Packs a full frame of codes into the flat vector consumed by layer0 neuron LUTs and holds it under a valid/ready handshake until the layer0 input register takes it.

---
 rtl/logicnet_pkg.sv | 38 +++
 rtl/logicnet_input_quantizer_feat_quant.sv | 29 ++
 rtl/logicnet_input_quantizer.sv | 148 ++++++++++++++
 tb/tb_logicnet_input_quantizer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/logicnet_pkg.sv
// Shared definitions for the LogicNet input quantizer.
//   - 2-bit quantization code constants
//   - frame assembly state enum
//   - thr_slice(): extracts one threshold from the packed threshold vector
package logicnet_pkg;

    // Upper bounds for the generic threshold accessor. Thresholds wider than
    // THR_MAX_FEAT_W, or packed vectors longer than THR_MAX_W, are not supported.
    localparam int unsigned THR_MAX_FEAT_W = 32;
    localparam int unsigned THR_MAX_W      = 4096;

    localparam logic [1:0] CODE_LT_T0 = 2'b00;  // x < T0
    localparam logic [1:0] CODE_LT_T1 = 2'b01;  // T0 <= x < T1
    localparam logic [1:0] CODE_LT_T2 = 2'b10;  // T1 <= x < T2
    localparam logic [1:0] CODE_GE_T2 = 2'b11;  // x >= T2

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        HOLD
    } state_e;

    // Threshold k (0..2) of feature i. Feature i occupies 3*feat_w bits at
    // offset 3*feat_w*i, with T0 in the lowest slice. Result is zero-extended.
    function automatic logic [THR_MAX_FEAT_W-1:0] thr_slice(
        input logic [THR_MAX_W-1:0] thresh,
        input int unsigned          feat_w,
        input int unsigned          i,
        input int unsigned          k
    );
        logic [THR_MAX_W-1:0]      sh;
        logic [THR_MAX_FEAT_W-1:0] mask;
        sh   = thresh >> ((3 * i + k) * feat_w);
        mask = (THR_MAX_FEAT_W'(1) << feat_w) - THR_MAX_FEAT_W'(1);
        return sh[THR_MAX_FEAT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/logicnet_input_quantizer_feat_quant.sv
// Combinational 2-bit quantizer for one signed sample.
//   sample     : signed input value
//   t0, t1, t2 : signed thresholds, expected t0 <= t1 <= t2
//   code       : 00 below t0, 01 below t1, 10 below t2, 11 otherwise
module logicnet_feat_quant
    import logicnet_pkg::*;
#(
    parameter int unsigned FEAT_W = 8
) (
    input  logic signed [FEAT_W-1:0] sample,
    input  logic signed [FEAT_W-1:0] t0,
    input  logic signed [FEAT_W-1:0] t1,
    input  logic signed [FEAT_W-1:0] t2,
    output logic        [1:0]        code
);

    always_comb begin
        if (sample < t0) begin
            code = CODE_LT_T0;
        end else if (sample < t1) begin
            code = CODE_LT_T1;
        end else if (sample < t2) begin
            code = CODE_LT_T2;
        end else begin
            code = CODE_GE_T2;
        end
    end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Input quantizer feeding the first LogicNet layer.
// Accepts one signed sample per beat, quantizes it against per-feature
// thresholds and packs a full frame of 2-bit codes for layer0.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : sample handshake; in_data sample, in_last frame end
//   out_valid/out_ready : packed frame handshake; out_codes[2i+1:2i] = feature i
//   frame_err           : one-cycle pulse on a short or long frame
module logicnet_input_quantizer
    import logicnet_pkg::*;
#(
    parameter int unsigned                  NUM_FEAT = 8,
    parameter int unsigned                  FEAT_W   = 8,
    parameter logic [NUM_FEAT*3*FEAT_W-1:0] THRESH   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FEAT_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_FEAT-1:0] out_codes,
    output logic                  frame_err
);

    localparam int unsigned IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic [THR_MAX_W-1:0] THRESH_EXT = THR_MAX_W'(THRESH);

    // Per-feature threshold tables, constant after elaboration
    logic signed [FEAT_W-1:0] t0_tab [NUM_FEAT];
    logic signed [FEAT_W-1:0] t1_tab [NUM_FEAT];
    logic signed [FEAT_W-1:0] t2_tab [NUM_FEAT];

    for (genvar g = 0; g < NUM_FEAT; g++) begin : g_thr
        assign t0_tab[g] = FEAT_W'(thr_slice(THRESH_EXT, FEAT_W, g, 0));
        assign t1_tab[g] = FEAT_W'(thr_slice(THRESH_EXT, FEAT_W, g, 1));
        assign t2_tab[g] = FEAT_W'(thr_slice(THRESH_EXT, FEAT_W, g, 2));
    end

    state_e state_q, state_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  s1_v_q;
    logic [FEAT_W-1:0]     s1_data_q;
    logic [IDX_W-1:0]      s1_idx_q;
    logic [1:0]            s1_code;
    logic [1:0]            shadow_q [NUM_FEAT];
    logic [2*NUM_FEAT-1:0] packed_d;
    logic [2*NUM_FEAT-1:0] out_codes_q;
    logic                  frame_err_q;

    logic accept, is_end, err_d, good_last;

    assign accept    = in_valid && in_ready;
    assign is_end    = (idx_q == LAST_IDX);
    // in_last must coincide exactly with the final index; anything else is a framing error
    assign err_d     = accept && (in_last != is_end);
    assign good_last = accept && in_last && is_end;

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = (in_last || is_end) ? '0 : idx_q + IDX_W'(1);
        end
    end

    logicnet_feat_quant #(
        .FEAT_W (FEAT_W)
    ) u_quant (
        .sample (s1_data_q),
        .t0     (t0_tab[s1_idx_q]),
        .t1     (t1_tab[s1_idx_q]),
        .t2     (t2_tab[s1_idx_q]),
        .code   (s1_code)
    );

    // Shadow vector with the in-flight stage-1 code merged in, so DRAIN can
    // publish the frame in the same edge that writes its final code.
    always_comb begin
        packed_d = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            packed_d[2*i +: 2] = shadow_q[i];
            if (s1_v_q && (s1_idx_q == IDX_W'(i))) begin
                packed_d[2*i +: 2] = s1_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
            frame_err_q <= 1'b0;
            out_codes_q <= '0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            s1_v_q      <= accept;
            frame_err_q <= err_d;
            if (accept) begin
                s1_data_q <= in_data;
                s1_idx_q  <= idx_q;
            end
            if (s1_v_q) begin
                shadow_q[s1_idx_q] <= s1_code;
            end
            if (state_q == DRAIN) begin
                out_codes_q <= packed_d;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (good_last) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM: outputs; in_ready is gated by rst so it reads 0 while reset is held
    always_comb begin
        in_ready  = (state_q == COLLECT) && !rst;
        out_valid = (state_q == HOLD);
    end

    assign out_codes = out_codes_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
module tb_logicnet_input_quantizer;

    localparam int unsigned NF = 3;
    localparam int unsigned FW = 8;
    // Every feature: T0=-10, T1=0, T2=10 (T0 in lowest byte)
    localparam logic [NF*3*FW-1:0] TH = {3{24'h0A_00_F6}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*NF-1:0] out_codes;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    logicnet_input_quantizer #(
        .NUM_FEAT (NF),
        .FEAT_W   (FW),
        .THRESH   (TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_codes (out_codes),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Reference: quantization rule evaluated on plain integers
    function automatic logic [1:0] ref_code(int x);
        if (x < -10) return 2'd0;
        if (x < 0)   return 2'd1;
        if (x < 10)  return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [5:0] ref_frame(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        int xa, xb, xc;
        xa = int'($signed(a));
        xb = int'($signed(b));
        xc = int'($signed(c));
        return {ref_code(xc), ref_code(xb), ref_code(xa)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [7:0] d, input logic last);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Full frame, then hold the output for 'stall' cycles of backpressure
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input int stall);
        logic [5:0] exp;
        exp = ref_frame(a, b, c);
        send_beat(a, 1'b0);
        send_beat(b, 1'b0);
        send_beat(c, 1'b1);
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = (stall == 0);
        step();
        chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_codes", {26'b0, out_codes}, {26'b0, exp});
        for (int k = 0; k < stall; k++) begin
            step();
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_codes", {26'b0, out_codes}, {26'b0, exp});
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        chk("handshake_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk("after_out_valid", {31'b0, out_valid}, 32'd0);
        chk("after_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb, rc;

        // Reset
        step();
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_codes", {26'b0, out_codes}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic frame and exact expected codes
        run_frame(8'hEC, 8'h00, 8'h0A, 0);            // -20, 0, 10
        chk("basic_const", {26'b0, ref_frame(8'hEC, 8'h00, 8'h0A)}, 32'b11_10_00);

        // Boundaries
        run_frame(8'hF5, 8'hF6, 8'h09, 0);            // -11, -10, 9
        run_frame(8'h7F, 8'h80, 8'h0A, 0);            // 127, -128, 10

        // Backpressure
        run_frame(8'h05, 8'hFB, 8'h64, 5);

        // Short frame
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b1);
        chk("short_err", {31'b0, frame_err}, 32'd1);
        chk("short_out_valid", {31'b0, out_valid}, 32'd0);
        chk("short_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("short_err_pulse", {31'b0, frame_err}, 32'd0);
        chk("short_no_valid", {31'b0, out_valid}, 32'd0);
        run_frame(8'h00, 8'h00, 8'h00, 0);
        chk("zero_frame_const", {26'b0, out_codes}, 32'b10_10_10);

        // Long frame
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        chk("long_err", {31'b0, frame_err}, 32'd1);
        chk("long_out_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("long_err_pulse", {31'b0, frame_err}, 32'd0);
        chk("long_no_valid", {31'b0, out_valid}, 32'd0);
        run_frame(8'hF5, 8'h7F, 8'hF6, 0);            // idx restarted at 0

        // Reset while holding a frame
        out_ready = 1'b0;
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0A, 1'b1);
        step();
        chk("pre_rst_hold", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        chk("hold_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("hold_rst_codes", {26'b0, out_codes}, 32'd0);
        chk("hold_rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("hold_rst_release", {31'b0, in_ready}, 32'd1);
        step();
        chk("hold_rst_dropped", {31'b0, out_valid}, 32'd0);

        // Randomized frames against the reference model
        for (int f = 0; f < 12; f++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            run_frame(ra, rb, rc, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
